// File: rtl/dram_arbiter.sv
// DRAM port arbiter: a processor run owns the DRAM port in RUN; otherwise a
// host single-beat read/write port is served. A watchdog bounds each run.
//
// state | meaning
// IDLE  | no run; host accesses and start accepted
// RUN   | processor owns DRAM, host stalled, watchdog counting
// DONE  | run finished normally; host accesses accepted
// FAULT | watchdog expired; host locked out until clear
// H_IDLE| no host access
// H_ACC | access cycle A (write strobe or read address issue)
// H_WAIT| read latency cycles A+1 .. A+RD_LAT
// H_ACK | one-cycle host_ack
module dram_arbiter #(
    parameter int unsigned       RD_LAT   = 1,
    parameter int unsigned       WDOG_W   = 24,
    parameter logic [WDOG_W-1:0] WDOG_MAX = 24'hFFFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        clear,
    input  logic        proc_finish,
    input  logic        proc_wr_en,
    input  logic [15:0] proc_addr,
    input  logic [7:0]  proc_din,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [15:0] host_addr,
    input  logic [7:0]  host_din,
    input  logic [7:0]  ram_out,
    output logic        proc_enable,
    output logic        dram_wr_en,
    output logic [15:0] dram_addr,
    output logic [7:0]  dram_din,
    output logic        host_ack,
    output logic [7:0]  host_rdata,
    output logic        busy,
    output logic        done,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE, FAULT} state_t;
    typedef enum logic [1:0] {H_IDLE, H_ACC, H_WAIT, H_ACK} hstate_t;

    state_t             state_q, state_d;
    hstate_t            hstate_q, hstate_d;
    logic [15:0]        haddr_q, haddr_d;
    logic [7:0]         hdin_q, hdin_d;
    logic               hwe_q, hwe_d;
    logic [7:0]         rdata_q, rdata_d;
    logic [7:0]         lat_q, lat_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic [WDOG_W-1:0]  wdog_inc;
    logic               fin_q, fin_d;
    logic               start_pend_q, start_pend_d;
    logic               clr_pend_q, clr_pend_d;
    logic               start_eff, clr_eff, h_free, go_run, accept;

    assign wdog_inc = wdog_q + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            hstate_q     <= H_IDLE;
            haddr_q      <= '0;
            hdin_q       <= '0;
            hwe_q        <= 1'b0;
            rdata_q      <= '0;
            lat_q        <= '0;
            wdog_q       <= '0;
            fin_q        <= 1'b0;
            start_pend_q <= 1'b0;
            clr_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hstate_q     <= hstate_d;
            haddr_q      <= haddr_d;
            hdin_q       <= hdin_d;
            hwe_q        <= hwe_d;
            rdata_q      <= rdata_d;
            lat_q        <= lat_d;
            wdog_q       <= wdog_d;
            fin_q        <= fin_d;
            start_pend_q <= start_pend_d;
            clr_pend_q   <= clr_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hstate_d   = hstate_q;
        haddr_d    = haddr_q;
        hdin_d     = hdin_q;
        hwe_d      = hwe_q;
        rdata_d    = rdata_q;
        lat_d      = lat_q;
        wdog_d     = wdog_q;
        clr_pend_d = clr_pend_q;
        fin_d      = proc_finish && (state_q == RUN);

        start_eff = start || start_pend_q;
        clr_eff   = clear || clr_pend_q;
        // The ack cycle counts as free so back-to-back accesses and a
        // pending start can both be taken at the edge that ends it.
        h_free    = (hstate_q == H_IDLE) || (hstate_q == H_ACK);
        go_run    = (state_q == IDLE) && start_eff &&
                    (((hstate_q == H_IDLE) && !host_req) || (hstate_q == H_ACK));
        accept    = host_req && h_free && !go_run &&
                    ((state_q == IDLE) || (state_q == DONE));
        start_pend_d = (state_q == IDLE) && start_eff && !go_run;

        case (state_q)
            IDLE: begin
                if (go_run) begin
                    state_d = RUN;
                    wdog_d  = '0;
                end
            end
            RUN: begin
                wdog_d = wdog_inc;
                if (fin_q) begin
                    state_d = DONE;
                end else if (wdog_inc == WDOG_MAX) begin
                    state_d = FAULT;
                end
            end
            default: begin
                if (clr_eff) begin
                    if (h_free) begin
                        state_d    = IDLE;
                        clr_pend_d = 1'b0;
                    end else begin
                        clr_pend_d = 1'b1;
                    end
                end
            end
        endcase

        if (accept) begin
            haddr_d = host_addr;
            hdin_d  = host_din;
            hwe_d   = host_we;
        end

        case (hstate_q)
            H_IDLE: begin
                if (accept) hstate_d = H_ACC;
            end
            H_ACC: begin
                if (hwe_q) begin
                    hstate_d = H_ACK;
                end else if (RD_LAT == 0) begin
                    rdata_d  = ram_out;
                    hstate_d = H_ACK;
                end else begin
                    lat_d    = 8'(RD_LAT - 1);
                    hstate_d = H_WAIT;
                end
            end
            H_WAIT: begin
                if (lat_q == '0) begin
                    rdata_d  = ram_out;
                    hstate_d = H_ACK;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            default: begin
                hstate_d = accept ? H_ACC : H_IDLE;
            end
        endcase
    end

    assign proc_enable = (state_q == RUN);
    assign dram_wr_en  = proc_enable ? proc_wr_en : ((hstate_q == H_ACC) && hwe_q);
    assign dram_addr   = proc_enable ? proc_addr : haddr_q;
    assign dram_din    = proc_enable ? proc_din : hdin_q;
    assign host_ack    = (hstate_q == H_ACK);
    assign host_rdata  = rdata_q;
    assign busy        = proc_enable || (hstate_q != H_IDLE);
    assign done        = (state_q == DONE);
    assign timeout_err = (state_q == FAULT);

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- RD_LAT, 1: DRAM read latency in clock cycles.
- WDOG_W, 24: watchdog counter width.
- WDOG_MAX, 24'hFFFFFF: watchdog terminal count.

REQ-002 Ports (name, direction, width, meaning):
- clock, in, 1: single clock for the whole block.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: request a processor run.
- clear, in, 1: return from DONE or FAULT to IDLE.
- proc_finish, in, 1: processor end-of-program flag.
- proc_wr_en, in, 1: processor DRAM write enable.
- proc_addr, in, 16: processor DRAM address.
- proc_din, in, 8: processor DRAM write data.
- host_req, in, 1: host access request, level.
- host_we, in, 1: host access type; 1 = write.
- host_addr, in, 16: host DRAM address.
- host_din, in, 8: host write data.
- ram_out, in, 8: DRAM read data.
- proc_enable, out, 1: enable to the processor.
- dram_wr_en, out, 1: DRAM write enable.
- dram_addr, out, 16: DRAM address.
- dram_din, out, 8: DRAM write data.
- host_ack, out, 1: one-cycle access-complete pulse.
- host_rdata, out, 8: read data returned to the host.
- busy, out, 1: run or host access in progress.
- done, out, 1: run completed normally.
- timeout_err, out, 1: watchdog expired.

Function
REQ-003 Top FSM states SHALL be IDLE, RUN, DONE and FAULT. The host sub-FSM SHALL be H_IDLE, H_ACC, H_WAIT and H_ACK.
REQ-004 Host access SHALL be accepted only in IDLE or DONE, and only when the sub-FSM is in H_IDLE. host_req=1 sampled at edge N SHALL latch host_addr, host_we and host_din; cycle N+1 is the access cycle A.
REQ-005 Host write SHALL drive dram_wr_en=1 with the latched addr and data for exactly cycle A, with host_ack=1 in cycle A+1.
REQ-006 Host read SHALL drive the latched addr from cycle A through A+RD_LAT. ram_out SHALL be captured into host_rdata at the end of cycle A+RD_LAT, with host_ack=1 in cycle A+RD_LAT+1 and host_rdata valid from that cycle until the next read capture.
REQ-007 Each acknowledged access SHALL produce exactly one host_ack. If host_req is still high in the ack cycle, a new access SHALL be sampled at the next edge (back-to-back accesses allowed).
REQ-008 start in IDLE with the sub-FSM in H_IDLE SHALL enter RUN at the next edge. start during a host access SHALL be held pending and taken in the cycle after host_ack. start in RUN, DONE or FAULT SHALL be ignored.
REQ-009 If start and host_req are both sampled in IDLE in the same cycle, the host access SHALL be served first and start SHALL be pending.
REQ-010 In RUN:
- proc_enable=1.
- dram_wr_en, dram_addr and dram_din SHALL combinationally follow proc_wr_en, proc_addr and proc_din.
- host_req SHALL be stalled (no ack) until RUN exits.
REQ-011 proc_finish SHALL be registered by one flop. The registered value =1 in RUN SHALL cause RUN->DONE, with proc_enable=0 from the first DONE cycle. proc_finish outside RUN SHALL be ignored.
REQ-012 The watchdog SHALL clear on entry to RUN and increment each RUN cycle. Reaching WDOG_MAX SHALL cause RUN->FAULT. Registered finish and terminal count in the same cycle SHALL go to DONE.
REQ-013 DONE SHALL hold done=1 and FAULT SHALL hold timeout_err=1. clear SHALL return either state to IDLE, deferred until any in-progress host access acks. FAULT SHALL accept no host access.
REQ-014 Outside RUN, dram_wr_en SHALL be 0 except in a host-write access cycle. dram_addr and dram_din SHALL hold the last latched host values.
REQ-015 busy SHALL be 1 in RUN, and 1 whenever the sub-FSM is not in H_IDLE.

Reset
REQ-016 On reset assertion, with no clock edge required, the following SHALL hold:
- state IDLE and sub-FSM H_IDLE.
- All outputs 0.
- Watchdog 0, pending start cleared, registered finish 0.
REQ-017 Reset during a host access SHALL abort it with no host_ack. Reset in RUN SHALL drop proc_enable immediately.

Verification
REQ-018 Host write followed by host read SHALL be covered: write addr 16'h0010 data 8'hA5, then read addr 16'h0010 with RD_LAT=1. Required: dram_wr_en high exactly 1 cycle; read ack 3 cycles after req sampled; host_rdata=8'hA5.
REQ-019 Normal run SHALL be covered: start, processor writes 8'h3C to 16'h0020, then proc_finish. Required: proc_enable=1 during RUN; DRAM pins track the processor; done=1 and proc_enable=0 two edges after finish rises.
REQ-020 Host during RUN SHALL be covered: host_req asserted while in RUN. Required: no host_ack until DONE; the access then completes with a single ack.
REQ-021 Watchdog SHALL be covered: WDOG_MAX=16, proc_finish never asserted. Required: FAULT with timeout_err=1 after 16 RUN cycles; clear returns to IDLE with all flags 0. Finish and terminal count in the same cycle -> done=1.
REQ-022 Simultaneous start+host_req in IDLE SHALL be covered: host ack first, RUN entered the cycle after the ack.
REQ-023 Async reset SHALL be covered: reset asserted mid-read and mid-RUN. Required: outputs 0 before the next clock edge; no host_ack issued.
